// File: rtl/uart_core.sv
// -----------------------------------------------------------------------------
// uart_core
//
// Full-duplex UART. Each direction has its own FIFO and a valid/ready byte
// interface. Data width, parity, stop bits, baud divisor and FIFO depth are
// set by parameters. The receiver reports framing, parity and overrun errors.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   rxd            serial input, asynchronous to clk
//   txd            serial output, idle high
//   tx_data        byte to transmit
//   tx_valid       tx_data is valid
//   tx_ready       TX FIFO not full
//   rx_data        head of RX FIFO (first-word fall-through)
//   rx_valid       RX FIFO not empty
//   rx_ready       consumer pops the RX head
//   rx_frame_err   one-cycle pulse on a bad stop bit
//   rx_parity_err  one-cycle pulse on a parity mismatch
//   rx_overrun     one-cycle pulse when a received byte is dropped (RX FIFO full)
//   tx_count       TX FIFO occupancy
//   rx_count       RX FIFO occupancy
// -----------------------------------------------------------------------------
module uart_core #(
    parameter int CLOCKS_PER_BIT = 2604,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_EN      = 0,
    parameter int PARITY_ODD     = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_AW        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic                 txd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic [FIFO_AW:0]     tx_count,
    output logic [FIFO_AW:0]     rx_count
);

    localparam int TW    = $clog2(CLOCKS_PER_BIT);
    localparam int CW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [TW-1:0]      T_ZERO    = TW'(0);
    localparam logic [TW-1:0]      T_ONE     = TW'(1);
    localparam logic [TW-1:0]      T_LAST    = TW'(CLOCKS_PER_BIT - 1);
    // RX START is entered one cycle after the synchronised falling edge, so
    // sampling at CLOCKS_PER_BIT/2 - 1 lands CLOCKS_PER_BIT/2 after the edge.
    localparam logic [TW-1:0]      T_HALF    = TW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [2:0]         B_ZERO    = 3'd0;
    localparam logic [2:0]         B_ONE     = 3'd1;
    localparam logic [2:0]         B_LAST    = 3'(DATA_BITS - 1);
    localparam logic               STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [FIFO_AW-1:0] P_ONE     = FIFO_AW'(1);
    localparam logic [CW-1:0]      C_ZERO    = CW'(0);
    localparam logic [CW-1:0]      C_ONE     = CW'(1);
    localparam logic [CW-1:0]      C_FULL    = CW'(DEPTH);
    localparam logic               PAR_ODD_C = 1'(PARITY_ODD);
    localparam logic               PAR_EN_C  = (PARITY_EN != 0);

    // Parity bit for a data word: XOR of the bits, inverted for odd parity.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        parity_of = (^d) ^ PAR_ODD_C;
    endfunction

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    // ------------------------------------------------------------------ TX FIFO
    logic [DATA_BITS-1:0] tx_mem_q [DEPTH];
    logic [FIFO_AW-1:0]   tx_wr_ptr_q, tx_wr_ptr_d;
    logic [FIFO_AW-1:0]   tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic                 tx_push_s;
    logic                 tx_pop_s;
    logic [DATA_BITS-1:0] tx_head_s;

    assign tx_ready  = (tx_cnt_q != C_FULL);
    assign tx_count  = tx_cnt_q;
    assign tx_push_s = tx_valid & tx_ready;
    assign tx_head_s = tx_mem_q[tx_rd_ptr_q];

    // TX FIFO pointer and occupancy update.
    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        if (tx_push_s) begin
            tx_wr_ptr_d = tx_wr_ptr_q + P_ONE;
        end else begin
            tx_wr_ptr_d = tx_wr_ptr_q;
        end
        if (tx_pop_s) begin
            tx_rd_ptr_d = tx_rd_ptr_q + P_ONE;
        end else begin
            tx_rd_ptr_d = tx_rd_ptr_q;
        end
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + C_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - C_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // TX FIFO storage; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wr_ptr_q] <= tx_data;
        end
    end

    // ------------------------------------------------------------------ TX FSM
    tx_state_e            tx_state_q, tx_state_d;
    logic [TW-1:0]        tx_timer_q, tx_timer_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic                 tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;
    logic                 tx_tick_s;

    assign tx_tick_s = (tx_timer_q == T_LAST);
    assign txd       = txd_q;

    // TX next state; txd is computed one cycle ahead so the pin is a flop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_pop_s   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_timer_d = T_ZERO;
                tx_bit_d   = B_ZERO;
                tx_stop_d  = 1'b0;
                if (tx_cnt_q != C_ZERO) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_d = tx_head_s;
                    tx_par_d   = parity_of(tx_head_s);
                    txd_d      = 1'b0;
                    tx_state_d = TX_START;
                end else begin
                    txd_d      = 1'b1;
                end
            end
            TX_START: begin
                if (tx_tick_s) begin
                    tx_timer_d = T_ZERO;
                    txd_d      = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_timer_d = tx_timer_q + T_ONE;
                end
            end
            TX_DATA: begin
                if (tx_tick_s) begin
                    tx_timer_d = T_ZERO;
                    if (tx_bit_q == B_LAST) begin
                        if (PAR_EN_C) begin
                            txd_d      = tx_par_q;
                            tx_state_d = TX_PARITY;
                        end else begin
                            txd_d      = 1'b1;
                            tx_state_d = TX_STOP;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + B_ONE;
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_timer_d = tx_timer_q + T_ONE;
                end
            end
            TX_PARITY: begin
                if (tx_tick_s) begin
                    tx_timer_d = T_ZERO;
                    txd_d      = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_timer_d = tx_timer_q + T_ONE;
                end
            end
            TX_STOP: begin
                txd_d = 1'b1;
                if (tx_tick_s) begin
                    tx_timer_d = T_ZERO;
                    if (tx_stop_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_stop_d  = 1'b1;
                    end
                end else begin
                    tx_timer_d = tx_timer_q + T_ONE;
                end
            end
            default: begin
                txd_d      = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // TX registers: FIFO pointers, FSM state and the txd output flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            tx_state_q  <= TX_IDLE;
            tx_timer_q  <= '0;
            tx_bit_q    <= '0;
            tx_stop_q   <= 1'b0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_timer_q  <= tx_timer_d;
            tx_bit_q    <= tx_bit_d;
            tx_stop_q   <= tx_stop_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            txd_q       <= txd_d;
        end
    end

    // ------------------------------------------------------------------ RX FSM
    rx_state_e            rx_state_q, rx_state_d;
    logic [TW-1:0]        rx_timer_q, rx_timer_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_bad_q, rx_par_bad_d;
    logic                 rx_frame_err_q, rx_frame_err_d;
    logic                 rx_parity_err_q, rx_parity_err_d;
    logic                 rx_meta_q, rx_sync_q;
    logic                 rx_push_req_s;
    logic                 rx_tick_s;

    assign rx_tick_s     = (rx_timer_q == T_LAST);
    assign rx_frame_err  = rx_frame_err_q;
    assign rx_parity_err = rx_parity_err_q;

    // RX next state; samples land at bit centres, counted from the start edge.
    always_comb begin
        rx_state_d      = rx_state_q;
        rx_timer_d      = rx_timer_q;
        rx_bit_d        = rx_bit_q;
        rx_shift_d      = rx_shift_q;
        rx_par_bad_d    = rx_par_bad_q;
        rx_frame_err_d  = 1'b0;
        rx_parity_err_d = 1'b0;
        rx_push_req_s   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_timer_d   = T_ZERO;
                rx_bit_d     = B_ZERO;
                rx_par_bad_d = 1'b0;
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_timer_q == T_HALF) begin
                    rx_timer_d = T_ZERO;
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;  // glitch, not a start bit
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_timer_d = rx_timer_q + T_ONE;
                end
            end
            RX_DATA: begin
                if (rx_tick_s) begin
                    rx_timer_d = T_ZERO;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == B_LAST) begin
                        if (PAR_EN_C) begin
                            rx_state_d = RX_PARITY;
                        end else begin
                            rx_state_d = RX_STOP;
                        end
                    end else begin
                        rx_bit_d = rx_bit_q + B_ONE;
                    end
                end else begin
                    rx_timer_d = rx_timer_q + T_ONE;
                end
            end
            RX_PARITY: begin
                if (rx_tick_s) begin
                    rx_timer_d   = T_ZERO;
                    rx_par_bad_d = (rx_sync_q != parity_of(rx_shift_q));
                    rx_state_d   = RX_STOP;
                end else begin
                    rx_timer_d = rx_timer_q + T_ONE;
                end
            end
            RX_STOP: begin
                if (rx_tick_s) begin
                    rx_timer_d = T_ZERO;
                    if (rx_sync_q) begin
                        if (rx_par_bad_q) begin
                            rx_parity_err_d = 1'b1;
                        end else begin
                            rx_push_req_s   = 1'b1;
                        end
                        rx_state_d = RX_IDLE;
                    end else begin
                        // Framing error takes precedence over parity.
                        rx_frame_err_d = 1'b1;
                        rx_state_d     = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_timer_d = rx_timer_q + T_ONE;
                end
            end
            RX_WAIT_HIGH: begin
                // A held-low line (break) must not look like a new start bit.
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_HIGH;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------ RX FIFO
    logic [DATA_BITS-1:0] rx_mem_q [DEPTH];
    logic [FIFO_AW-1:0]   rx_wr_ptr_q, rx_wr_ptr_d;
    logic [FIFO_AW-1:0]   rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic                 rx_overrun_q, rx_overrun_d;
    logic                 rx_push_s;
    logic                 rx_pop_s;
    logic                 rx_full_s;

    assign rx_valid   = (rx_cnt_q != C_ZERO);
    assign rx_count   = rx_cnt_q;
    assign rx_data    = rx_mem_q[rx_rd_ptr_q];
    assign rx_overrun = rx_overrun_q;
    assign rx_full_s  = (rx_cnt_q == C_FULL);
    assign rx_pop_s   = rx_valid & rx_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign rx_push_s  = rx_push_req_s & (~rx_full_s | rx_pop_s);

    // RX FIFO pointer, occupancy and overrun update.
    always_comb begin
        rx_wr_ptr_d  = rx_wr_ptr_q;
        rx_rd_ptr_d  = rx_rd_ptr_q;
        rx_cnt_d     = rx_cnt_q;
        rx_overrun_d = rx_push_req_s & rx_full_s & ~rx_pop_s;
        if (rx_push_s) begin
            rx_wr_ptr_d = rx_wr_ptr_q + P_ONE;
        end else begin
            rx_wr_ptr_d = rx_wr_ptr_q;
        end
        if (rx_pop_s) begin
            rx_rd_ptr_d = rx_rd_ptr_q + P_ONE;
        end else begin
            rx_rd_ptr_d = rx_rd_ptr_q;
        end
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + C_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - C_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // RX FIFO storage; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_q[rx_wr_ptr_q] <= rx_shift_q;
        end
    end

    // RX registers: synchroniser, FSM state, FIFO pointers and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q       <= 1'b1;
            rx_sync_q       <= 1'b1;
            rx_state_q      <= RX_IDLE;
            rx_timer_q      <= '0;
            rx_bit_q        <= '0;
            rx_shift_q      <= '0;
            rx_par_bad_q    <= 1'b0;
            rx_frame_err_q  <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_overrun_q    <= 1'b0;
            rx_wr_ptr_q     <= '0;
            rx_rd_ptr_q     <= '0;
            rx_cnt_q        <= '0;
        end else begin
            rx_meta_q       <= rxd;
            rx_sync_q       <= rx_meta_q;
            rx_state_q      <= rx_state_d;
            rx_timer_q      <= rx_timer_d;
            rx_bit_q        <= rx_bit_d;
            rx_shift_q      <= rx_shift_d;
            rx_par_bad_q    <= rx_par_bad_d;
            rx_frame_err_q  <= rx_frame_err_d;
            rx_parity_err_q <= rx_parity_err_d;
            rx_overrun_q    <= rx_overrun_d;
            rx_wr_ptr_q     <= rx_wr_ptr_d;
            rx_rd_ptr_q     <= rx_rd_ptr_d;
            rx_cnt_q        <= rx_cnt_d;
        end
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
Parametrised full-duplex UART with independent TX and RX FIFOs and valid/ready byte interfaces.
- Supersedes the fixed 8N1 echo UART.
- Configurable data width, parity, stop bits, baud divisor and FIFO depth.
- Framing, parity and overrun error reporting.
- Sits between the host serial pins and any on-chip byte producer/consumer, e.g. a command parser or loopback.

Parameters:
CLOCKS_PER_BIT, 2604, clk cycles per serial bit (19200 baud at 50 MHz); must be >= 4.
DATA_BITS, 8, data bits per frame, 5..8, LSB first.
PARITY_EN, 0, 1 = parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
STOP_BITS, 1, stop bits sent by TX, 1 or 2. RX checks only the first stop bit.
FIFO_AW, 4, log2 FIFO depth; each FIFO holds 2**FIFO_AW entries.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
rxd  in  1  serial input, asynchronous to clk.
txd  out  1  serial output, idle high.
tx_data  in  DATA_BITS  byte to transmit.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  TX FIFO not full.
rx_data  out  DATA_BITS  head of RX FIFO (first-word fall-through).
rx_valid  out  1  RX FIFO not empty.
rx_ready  in  1  consumer pops the RX head.
rx_frame_err  out  1  one-cycle pulse on a bad stop bit.
rx_parity_err  out  1  one-cycle pulse on a parity mismatch.
rx_overrun  out  1  one-cycle pulse when a received byte is dropped because the RX FIFO is full.
tx_count  out  FIFO_AW+1  TX FIFO occupancy.
rx_count  out  FIFO_AW+1  RX FIFO occupancy.

Behaviour:
Reset (asynchronous assert):
- txd=1, tx_ready=1, rx_valid=0.
- All error pulses 0, both counts 0, both FSMs to IDLE, FIFOs emptied.
- A frame in progress is abandoned; txd returns high immediately.

FIFOs:
- Circular buffers with FIFO_AW-bit pointers that wrap modulo depth, plus occupancy counters.
- TX push on tx_valid&tx_ready.
- RX pop on rx_valid&rx_ready; rx_data is valid whenever rx_valid=1.
- Simultaneous push and pop leaves the count unchanged.
- RX push when full is accepted only if a pop occurs in the same cycle; otherwise the byte is dropped and rx_overrun pulses.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE: when tx_count != 0, pop the head into a shift register and enter START on the next edge. txd goes low the cycle after the pop.
- Each state holds txd for exactly CLOCKS_PER_BIT cycles, counted by a bit-timer of width clog2(CLOCKS_PER_BIT).
- DATA shifts out DATA_BITS bits, LSB first.
- PARITY is entered only if PARITY_EN=1 and sends the XOR of the data bits, XORed with PARITY_ODD.
- STOP holds txd=1 for STOP_BITS*CLOCKS_PER_BIT cycles, then returns to IDLE.
- Back-to-back bytes leave no idle gap beyond the stop bits plus 1 cycle.

RX FSM (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH):
- rxd passes through a 2-FF synchroniser; all RX logic uses the synchronised signal.
- IDLE: a synchronised low enters START with the timer cleared.
- START: at CLOCKS_PER_BIT/2 (integer division), resample. If high, treat as a false start and return to IDLE with no pulse; else enter DATA.
- DATA: sample every CLOCKS_PER_BIT cycles (bit centres), LSB first, DATA_BITS samples.
- PARITY (if enabled): sample one bit and compare.
- STOP: sample one bit.
  - High, parity OK: push the byte (subject to the overrun rule); go to IDLE.
  - High, parity bad: drop the byte, pulse rx_parity_err; go to IDLE.
  - Low: drop the byte, pulse rx_frame_err, enter WAIT_HIGH. Parity error is not also flagged.
- WAIT_HIGH: stay until the synchronised rxd is 1, then IDLE. This prevents a break condition from retriggering a frame.
- Latency: the byte appears on rx_valid 1 cycle after the stop-bit sample.

TX and RX are fully independent; external loopback (txd->rxd) must work at any queue depth.

Test Plan:
1. CLOCKS_PER_BIT=16, 8N1; push 0xA5 -> txd low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16; tx_count returns to 0.
2. Loopback txd->rxd, push 0x00,0xFF,0x3C back-to-back -> rx_data yields 0x00,0xFF,0x3C in order, no error pulses, tx_ready stays 1.
3. PARITY_EN=1, PARITY_ODD=0; drive frame 0x07 with parity bit 0 -> rx_parity_err pulses once, rx_count stays 0. Then drive parity bit 1 -> 0x07 received.
4. Drive 0x55 with stop bit 0 -> rx_frame_err pulse, no push. Hold rxd low 50 bit-times -> no further frames or pulses. Then rxd high, send 0x12 -> 0x12 received.
5. FIFO_AW=2, rx_ready=0; send 5 bytes 0x01..0x05 -> rx_count=4, rx_overrun pulses once on byte 5, rx_data=0x01. Pop all -> 0x01..0x04.
6. Push 6 bytes with FIFO_AW=2 -> tx_ready=0 at count 4. Assert reset mid-data-bit -> txd=1 and tx_count=0 immediately; after release no residual frame is sent.
